// File: rtl/jesd204b_rx_lane_sync.sv
// jesd204b_rx_lane_sync: per-lane JESD204B code-group synchroniser with LMFC-aligned SYNC~ release
// Ports:
//   i_dclk        RX user clock (rxusrclk2 domain)
//   i_rst_n       asynchronous active-low reset
//   i_reset_done  transceiver RX reset done; low forces every lane back to IDLE
//   i_sysref      SYSREF, already synchronous to i_dclk
//   i_rx_data     lane data, lane l at [l*USERDATA_WIDTH +: USERDATA_WIDTH]
//   i_rx_charisk  per-byte K-character flags
//   i_rx_err      per-byte disparity / not-in-table error
//   o_rxslide     one-cycle RXSLIDE pulse per lane
//   o_lane_locked per-lane CGS lock
//   o_nsync       SYNC~ (active-low, high once all lanes are synchronised)
//   o_data_valid  data phase active, one cycle behind o_nsync
//   o_data        i_rx_data delayed by one cycle
//   o_lmfc_cnt    current LMFC phase
module jesd204b_rx_lane_sync #(
   parameter int LANES          = 1,
   parameter int USERDATA_WIDTH = 32,
   parameter int LMFC_CNT_WIDTH = 8,
   parameter int LMFC_PERIOD    = 16,
   parameter int CGS_LOCK_CNT   = 4,
   parameter int CGS_LOSS_CNT   = 3,
   parameter int SLIDE_WAIT     = 32,
   parameter int SYNC_MODE      = 1
) (
   input  logic                                i_dclk,
   input  logic                                i_rst_n,
   input  logic                                i_reset_done,
   input  logic                                i_sysref,
   input  logic [LANES*USERDATA_WIDTH-1:0]     i_rx_data,
   input  logic [LANES*(USERDATA_WIDTH/8)-1:0] i_rx_charisk,
   input  logic [LANES*(USERDATA_WIDTH/8)-1:0] i_rx_err,
   output logic [LANES-1:0]                    o_rxslide,
   output logic [LANES-1:0]                    o_lane_locked,
   output logic                                o_nsync,
   output logic                                o_data_valid,
   output logic [LANES*USERDATA_WIDTH-1:0]     o_data,
   output logic [LMFC_CNT_WIDTH-1:0]           o_lmfc_cnt
);
   localparam int BYTES = USERDATA_WIDTH / 8;
   localparam int LW = $clog2(CGS_LOCK_CNT + 1);
   localparam int EW = $clog2(CGS_LOSS_CNT + 1);
   localparam int WW = $clog2(SLIDE_WAIT + 1);
   localparam logic [LW-1:0] LOCK_MAX = LW'(CGS_LOCK_CNT);
   localparam logic [EW-1:0] LOSS_MAX = EW'(CGS_LOSS_CNT);
   localparam logic [WW-1:0] WAIT_LAST = WW'(SLIDE_WAIT - 1);
   localparam logic [LMFC_CNT_WIDTH-1:0] LMFC_LAST = LMFC_CNT_WIDTH'(LMFC_PERIOD - 1);

   typedef enum logic [2:0] {IDLE, HUNT, SLIDE, WAIT, LOCKED} cgs_state_t;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      cgs_state_t      state, state_d;
      logic [LW-1:0]   lock_cnt, lock_cnt_d, lock_inc;
      logic [EW-1:0]   err_cnt, err_cnt_d, err_inc;
      logic [WW-1:0]   wait_cnt, wait_cnt_d, wait_inc;
      logic            comma, any_err, slide_q;

      // a comma word is K28.5 in every byte with no code errors
      always_comb begin
         comma = &i_rx_charisk[l*BYTES +: BYTES] & ~|i_rx_err[l*BYTES +: BYTES];
         for (int b = 0; b < BYTES; b++)
            comma = comma & (i_rx_data[l*USERDATA_WIDTH + b*8 +: 8] == 8'hBC);
      end

      assign any_err  = |i_rx_err[l*BYTES +: BYTES];
      assign lock_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 1'b1;
      assign err_inc  = (err_cnt == LOSS_MAX) ? err_cnt : err_cnt + 1'b1;
      assign wait_inc = (wait_cnt == WAIT_LAST) ? wait_cnt : wait_cnt + 1'b1;

      always_comb begin
         state_d    = state;
         lock_cnt_d = lock_cnt;
         err_cnt_d  = err_cnt;
         wait_cnt_d = '0;
         if (!i_reset_done) begin
            state_d    = IDLE;
            lock_cnt_d = '0;
            err_cnt_d  = '0;
         end else begin
            case (state)
               IDLE:  state_d = HUNT;
               HUNT:
                  if (comma) begin
                     lock_cnt_d = lock_inc;
                     if (lock_inc == LOCK_MAX) begin
                        state_d    = LOCKED;
                        lock_cnt_d = '0;
                     end
                  end else begin
                     lock_cnt_d = '0;
                     state_d    = SLIDE;
                  end
               SLIDE: state_d = WAIT;
               // the GTH needs quiet time after a slide, so input is ignored here
               WAIT:
                  if (wait_cnt == WAIT_LAST) state_d = HUNT;
                  else wait_cnt_d = wait_inc;
               LOCKED:
                  if (any_err) begin
                     err_cnt_d = err_inc;
                     if (err_inc == LOSS_MAX) begin
                        state_d   = HUNT;
                        err_cnt_d = '0;
                     end
                  end else begin
                     err_cnt_d = '0;
                  end
               default: state_d = IDLE;
            endcase
         end
      end

      // slide is registered from the transition so a reset_done drop cannot glitch it
      always_ff @(posedge i_dclk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            state    <= IDLE;
            lock_cnt <= '0;
            err_cnt  <= '0;
            wait_cnt <= '0;
            slide_q  <= 1'b0;
         end else begin
            state    <= state_d;
            lock_cnt <= lock_cnt_d;
            err_cnt  <= err_cnt_d;
            wait_cnt <= wait_cnt_d;
            slide_q  <= (state_d == SLIDE);
         end
      end

      assign o_rxslide[l]     = slide_q;
      assign o_lane_locked[l] = (state == LOCKED);
   end

   logic                      sysref_q, all_locked, nsync_d;
   logic [LMFC_CNT_WIDTH-1:0] lmfc_d;

   assign all_locked = &o_lane_locked;
   // a SYSREF edge wins over the natural wrap
   assign lmfc_d = (i_sysref & ~sysref_q) ? '0 : (o_lmfc_cnt == LMFC_LAST) ? '0 : o_lmfc_cnt + 1'b1;
   // release may only start on an LMFC boundary in mode 1; falling is never aligned
   assign nsync_d = i_reset_done & all_locked & ((SYNC_MODE == 0) | o_nsync | (lmfc_d == '0));

   always_ff @(posedge i_dclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sysref_q     <= 1'b0;
         o_lmfc_cnt   <= '0;
         o_nsync      <= 1'b0;
         o_data_valid <= 1'b0;
         o_data       <= '0;
      end else begin
         sysref_q     <= i_sysref;
         o_lmfc_cnt   <= lmfc_d;
         o_nsync      <= nsync_d;
         o_data_valid <= o_nsync;
         o_data       <= i_rx_data;
      end
   end
endmodule

// File: doc/jesd204b_rx_lane_sync.md
# jesd204b_rx_lane_sync

Multi-lane JESD204B receive synchroniser. It sits between the GTH wizard RX user-data outputs and the JESD204B receive core. Each lane runs its own code-group-synchronisation (CGS) state machine, which bit-aligns the lane by pulsing RXSLIDE until K28.5 comma words arrive. Once every lane is locked, the block releases `o_nsync`, either immediately or on an LMFC boundary derived from SYSREF, and then forwards registered lane data with a valid flag.

## Interface
- `LANES`, 1: number of lanes (1–8).
- `USERDATA_WIDTH`, 32: per-lane data width in bits; must be a multiple of 8. `BYTES = USERDATA_WIDTH/8`.
- `LMFC_CNT_WIDTH`, 8: width of the LMFC counter.
- `LMFC_PERIOD`, 16: LMFC period in `i_dclk` cycles; range 2..2^LMFC_CNT_WIDTH.
- `CGS_LOCK_CNT`, 4: number of consecutive comma words required to lock a lane.
- `CGS_LOSS_CNT`, 3: number of consecutive error words that drops a lane's lock.
- `SLIDE_WAIT`, 32: guard cycles after each RXSLIDE pulse; minimum 32 per the GTH requirement.
- `SYNC_MODE`, 1: 0 = release nsync as soon as all lanes lock; 1 = release nsync on an LMFC boundary.

Ports (name, direction, width, meaning):
- `i_dclk` in 1: single clock, the RX user clock (rxusrclk2 domain).
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_reset_done` in 1: transceiver RX reset done.
- `i_sysref` in 1: SYSREF, already synchronous to `i_dclk`.
- `i_rx_data` in LANES*USERDATA_WIDTH: lane data; lane l occupies `[l*USERDATA_WIDTH +: USERDATA_WIDTH]`.
- `i_rx_charisk` in LANES*BYTES: K-character flag per byte.
- `i_rx_err` in LANES*BYTES: per-byte disparity or not-in-table error (OR of both).
- `o_rxslide` out LANES: one-cycle slide pulse per lane.
- `o_lane_locked` out LANES: per-lane CGS lock.
- `o_nsync` out 1: JESD204B SYNC~, active-low.
- `o_data_valid` out 1: data phase active.
- `o_data` out LANES*USERDATA_WIDTH: registered copy of `i_rx_data`.
- `o_lmfc_cnt` out LMFC_CNT_WIDTH: current LMFC phase.

## Operation
- **Comma word:** every byte of the lane word equals 8'hBC, its `charisk` bit is 1, and its `err` bit is 0.
- **Per-lane FSM** (IDLE, HUNT, SLIDE, WAIT, LOCKED):
  - IDLE → HUNT when `i_reset_done` = 1.
  - HUNT, comma word: `lock_cnt`++. On reaching `CGS_LOCK_CNT`, go to LOCKED and clear `lock_cnt`.
  - HUNT, any other word: clear `lock_cnt`, go to SLIDE.
  - SLIDE: `o_rxslide[l]` = 1 for this single cycle, then go to WAIT.
  - WAIT: count `SLIDE_WAIT` cycles, ignoring all input, then go to HUNT.
  - LOCKED, any `err` bit set: `err_cnt`++. On reaching `CGS_LOSS_CNT`, go to HUNT and clear `err_cnt`.
  - LOCKED, error-free word: clear `err_cnt`. Non-comma words are legal in LOCKED (ILAS and user data).
  - Any state → IDLE when `i_reset_done` = 0. This has priority over all other transitions.
- **LMFC counter:**
  - Free-running 0..LMFC_PERIOD-1 with wrap.
  - `i_sysref` is registered once. A rising edge (`i_sysref` & ~`sysref_q`) forces the count to 0 in the next cycle.
  - A SYSREF edge takes priority over the wrap.
- **nsync:**
  - `all_locked` = AND of `o_lane_locked`.
  - `SYNC_MODE` = 0: `o_nsync` follows `all_locked`, registered.
  - `SYNC_MODE` = 1: `o_nsync` rises only in the cycle where `o_lmfc_cnt` becomes 0 while `all_locked` = 1.
  - In both modes, `o_nsync` falls one cycle after `all_locked` drops or `i_reset_done` = 0, with no LMFC alignment on the fall.
  - If the release condition and a lane loss coincide, `o_nsync` stays 0.
- **Data path:** `o_data` <= `i_rx_data` every cycle. `o_data_valid` <= `o_nsync` registered, so valid is 1 exactly one cycle after `o_nsync` rises.
- **Counter widths:**
  - `lock_cnt`: clog2(CGS_LOCK_CNT+1).
  - `err_cnt`: clog2(CGS_LOSS_CNT+1).
  - Wait counter: clog2(SLIDE_WAIT+1).
  - All counters saturate; none wraps.

## Timing
- **Reset values:** all FSMs in IDLE; `o_rxslide` = 0; `o_lane_locked` = 0; `o_nsync` = 0; `o_data_valid` = 0; `o_data` = 0; `o_lmfc_cnt` = 0; all counters = 0.
- **Asynchronous reset:** assertion clears state immediately, including mid-slide or mid-data. Deassertion takes effect at the next `i_dclk` edge.
- **Slide timing:** a non-comma word sampled in HUNT at cycle t gives `o_rxslide` = 1 at t+1, WAIT for cycles t+2..t+1+SLIDE_WAIT, and the first HUNT sample at t+2+SLIDE_WAIT.
- **Lock timing:** the `CGS_LOCK_CNT`-th consecutive comma word at cycle t gives `o_lane_locked` = 1 at t+1.
- **Release timing:** `SYNC_MODE` = 0 gives `o_nsync` = 1 at t+2 and `o_data_valid` = 1 at t+3.
- **Loss timing:** the `CGS_LOSS_CNT`-th consecutive error word at cycle t gives `o_lane_locked` = 0 at t+1 and `o_nsync` = 0 at t+2.
- **SYSREF timing:** a rising edge at cycle t (`i_sysref` = 1, `sysref_q` = 0) gives `o_lmfc_cnt` = 0 at t+1.
- **Latency:** `o_data` is `i_rx_data` delayed by 1 cycle.

## Test plan
- **Aligned lock:** LANES=2, SYNC_MODE=0, `i_reset_done`=1, both lanes drive 32'hBCBCBCBC with charisk 4'hF.
  - `o_rxslide` never pulses.
  - `o_lane_locked` = 2'b11 after 4 words.
  - `o_nsync` rises 1 cycle later; `o_data_valid` rises 1 cycle after that.
- **Slide hunt:** lane 0 misaligned (32'h5E5E5E5E, charisk 0) for 2 slide attempts, then commas.
  - Exactly 2 one-cycle `o_rxslide[0]` pulses, spaced 34 cycles apart (pulse + 32 WAIT + 1 HUNT sample).
  - Lock 4 words after the commas start.
- **LMFC release:** SYNC_MODE=1, LMFC_PERIOD=16, SYSREF edge, then all lanes lock when `o_lmfc_cnt` = 5.
  - `o_nsync` stays 0 until `o_lmfc_cnt` becomes 0, then rises in that cycle.
  - A second SYSREF edge at count 9 resets the count to 0 one cycle later.
- **Loss of lock:** after data phase, inject `i_rx_err` = 4'h1 on lane 1.
  - 2 error words followed by a clean word keep the lane locked.
  - 3 consecutive error words drop `o_lane_locked[1]`, and `o_nsync` = 0 one cycle later.
  - The lane re-enters HUNT.
- **Reset mid-operation:**
  - Assert `i_rst_n`=0 during a WAIT: all outputs go to their reset values immediately.
  - Drop `i_reset_done` in the data phase: all lanes return to IDLE, `o_nsync` = 0 the next cycle, and `o_rxslide` stays 0.
